// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter slice.
// Register-zero constant, FSM state encoding and the buffered result entry.
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  localparam logic [WB_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    S_NORMAL,
    S_DRAIN
  } wb_state_t;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_if.sv
// Write-back bus: ALU and mul/div result inputs, decode hazard query, RF write.
// master = result producers / decode side, slave = wb_arbiter.
interface wb_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_stall;

  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_rd;
  logic [DW-1:0] md_data;

  logic [AW-1:0] chk_addr;
  logic          chk_hit;

  logic          write;
  logic [AW-1:0] Rd_addr;
  logic [DW-1:0] Rd_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output md_valid, md_rd, md_data,
    output chk_addr,
    input  alu_stall, md_ready, chk_hit,
    input  write, Rd_addr, Rd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  md_valid, md_rd, md_data,
    input  chk_addr,
    output alu_stall, md_ready, chk_hit,
    output write, Rd_addr, Rd_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Sync FIFO for mul/div results with occupancy count and head view.
// Ports: push/pop + entry in, head/count out, chk_addr -> chk_hit rd compare.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_rd,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_rd,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_hit
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count
             + {{PW{1'b0}}, push}
             - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr]   <= push_rd;
      data_mem[wptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rptr];
  assign head_data = data_mem[rptr];

  // Slot i is live when its distance from the head is below count.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - rptr} < count)
          && (rd_mem[i] == chk_addr))
        chk_hit = 1'b1;
    end
    if (chk_addr == AW'(REG_ZERO))
      chk_hit = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter owning the single RF write port (ALU vs mul/div).
// Ports: clk, rst, bus (wb_if.slave): alu_*, md_*, chk_*, write/Rd_addr/Rd_data.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DW       = 32,
  parameter int AW       = 5
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);

  wb_state_t     state;
  wb_state_t     state_nx;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nx;
  logic          stall_q;

  logic [PW:0]   count;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic          fifo_ne;
  logic          md_acc;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          drain;

  logic          win;
  logic [AW-1:0] win_rd;
  logic [DW-1:0] win_data;

  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (bus.md_rd),
    .push_data (bus.md_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .chk_addr  (bus.chk_addr),
    .chk_hit   (bus.chk_hit)
  );

  // No push when full, even if the head pops this cycle.
  assign bus.md_ready = (count < (PW+1)'(DEPTH));
  assign fifo_ne      = (count != '0);
  assign md_acc       = bus.md_valid && bus.md_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_NORMAL;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      stall_q  <= (state_nx == S_DRAIN);
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    unique case (state)
      S_NORMAL: begin
        if (pop) begin
          wait_nx = '0;
        end else if (fifo_ne && bus.alu_valid) begin
          wait_nx = wait_cnt + 1'b1;
          if (wait_nx == CW'(MAX_WAIT - 1))
            state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_nx = S_NORMAL;
        wait_nx  = '0;
      end
    endcase
  end

  assign drain         = (state == S_DRAIN);
  assign bus.alu_stall = stall_q;

  // Winner priority: forced drain, ALU, FIFO head, bypass.
  always_comb begin
    win      = 1'b0;
    win_rd   = bus.alu_rd;
    win_data = bus.alu_data;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (drain) begin
      win      = 1'b1;
      win_rd   = head_rd;
      win_data = head_data;
      pop      = 1'b1;
    end else if (bus.alu_valid) begin
      win = 1'b1;
    end else if (fifo_ne) begin
      win      = 1'b1;
      win_rd   = head_rd;
      win_data = head_data;
      pop      = 1'b1;
    end else if (md_acc) begin
      win      = 1'b1;
      win_rd   = bus.md_rd;
      win_data = bus.md_data;
      bypass   = 1'b1;
    end
  end

  assign push = md_acc && !bypass;

  // rd==0 results are consumed without a write; address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (win && (win_rd != AW'(REG_ZERO))) begin
      write_q <= 1'b1;
      addr_q  <= win_rd;
      data_q  <= win_data;
    end else begin
      write_q <= 1'b0;
    end
  end

  assign bus.write   = write_q;
  assign bus.Rd_addr = addr_q;
  assign bus.Rd_data = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int AW       = WB_AW;
  localparam int DW       = WB_DW;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_if #(.AW(AW), .DW(DW)) bus ();

  wb_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT),
    .DW       (DW),
    .AW       (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending mul/div results in acceptance order.
  wb_entry_t     q[$];
  int            m_wait;
  bit            m_drain;
  bit            e_write;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    q.delete();
    m_wait  = 0;
    m_drain = 0;
    e_write = 0;
    e_addr  = '0;
    e_data  = '0;
  endtask

  task automatic model_step();
    wb_entry_t w;
    wb_entry_t n;
    bit has;
    bit byp;
    bit acc;
    has = 0;
    byp = 0;
    w   = '0;
    acc = bus.md_valid && (q.size() < DEPTH);
    if (m_drain) begin
      w = q.pop_front();
      has = 1;
      m_drain = 0;
      m_wait = 0;
    end else if (bus.alu_valid) begin
      w.rd = bus.alu_rd;
      w.data = bus.alu_data;
      has = 1;
      if (q.size() > 0) begin
        m_wait++;
        if (m_wait == MAX_WAIT - 1) m_drain = 1;
      end
    end else if (q.size() > 0) begin
      w = q.pop_front();
      has = 1;
      m_wait = 0;
    end else if (acc) begin
      w.rd = bus.md_rd;
      w.data = bus.md_data;
      has = 1;
      byp = 1;
    end
    if (acc && !byp) begin
      n.rd = bus.md_rd;
      n.data = bus.md_data;
      q.push_back(n);
    end
    e_write = has && (w.rd != REG_ZERO);
    if (e_write) begin
      e_addr = w.rd;
      e_data = w.data;
    end
  endtask

  function automatic bit model_hit(input logic [AW-1:0] a);
    if (a == REG_ZERO) return 0;
    foreach (q[i]) if (q[i].rd == a) return 1;
    return 0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.md_valid  = 1'b0;
    bus.md_rd     = '0;
    bus.md_data   = '0;
    bus.chk_addr  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.write !== 1'b0 || bus.Rd_addr !== '0 || bus.Rd_data !== '0) begin
      errors++;
      $display("FAIL reset_init got %b/%0d/%h exp 0/0/0",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = AW'(i + 1);
      bus.alu_data  = DW'(32'h100 + i);
      bus.md_valid  = 1'b1;
      bus.md_rd     = AW'(20 + i);
      bus.md_data   = DW'(32'h200 + i);
      tick();
    end
    idle();
    bus.chk_addr = 5'd21;
    #1;
    checks++;
    if (bus.chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_hit got %b exp 1", bus.chk_hit);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.write !== 1'b0 || bus.Rd_addr !== '0 || bus.Rd_data !== '0) begin
      errors++;
      $display("FAIL rst_out got %b/%0d/%h exp 0/0/0",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    checks++;
    if (bus.md_ready !== 1'b1 || bus.chk_hit !== 1'b0 || bus.alu_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got rdy=%b hit=%b stall=%b exp 1/0/0",
               bus.md_ready, bus.chk_hit, bus.alu_stall);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h1234;
    tick();
    checks++;
    if (bus.write !== 1'b1 || bus.Rd_addr !== 5'd5 || bus.Rd_data !== 32'h1234) begin
      errors++;
      $display("FAIL alu_write got %b/%0d/%h exp 1/5/1234",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    idle();
    tick();
    checks++;
    if (bus.write !== 1'b0 || bus.Rd_addr !== 5'd5 || bus.Rd_data !== 32'h1234) begin
      errors++;
      $display("FAIL idle_hold got %b/%0d/%h exp 0/5/1234",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
  endtask

  task automatic test_alu_md();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h3333;
    bus.md_valid  = 1'b1;
    bus.md_rd     = 5'd7;
    bus.md_data   = 32'hAAAA;
    tick();
    checks++;
    if (bus.write !== 1'b1 || bus.Rd_addr !== 5'd3 || bus.Rd_data !== 32'h3333) begin
      errors++;
      $display("FAIL both_alu got %b/%0d/%h exp 1/3/3333",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    idle();
    bus.chk_addr = 5'd7;
    #1;
    checks++;
    if (bus.chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL pend_hit got %b exp 1", bus.chk_hit);
    end
    tick();
    checks++;
    if (bus.write !== 1'b1 || bus.Rd_addr !== 5'd7 || bus.Rd_data !== 32'hAAAA) begin
      errors++;
      $display("FAIL both_md got %b/%0d/%h exp 1/7/AAAA",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    tick();
    checks++;
    if (bus.write !== 1'b0) begin
      errors++;
      $display("FAIL both_idle got %b exp 0", bus.write);
    end
  endtask

  task automatic test_full_chk();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = AW'(i + 1);
      bus.alu_data  = DW'(i);
      bus.md_valid  = 1'b1;
      bus.md_rd     = AW'(7 + i);
      bus.md_data   = DW'(32'h700 + i);
      tick();
    end
    bus.md_valid = 1'b0;
    #1;
    checks++;
    if (bus.md_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b exp 0", bus.md_ready);
    end
    bus.chk_addr = 5'd7;
    #1;
    checks++;
    if (bus.chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL chk7 got %b exp 1", bus.chk_hit);
    end
    bus.chk_addr = 5'd10;
    #1;
    checks++;
    if (bus.chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL chk10 got %b exp 1", bus.chk_hit);
    end
    bus.chk_addr = 5'd0;
    #1;
    checks++;
    if (bus.chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk0 got %b exp 0", bus.chk_hit);
    end
    bus.chk_addr = 5'd11;
    #1;
    checks++;
    if (bus.chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk11 got %b exp 0", bus.chk_hit);
    end
    // Offer while full and popping: must not be taken.
    bus.alu_valid = 1'b0;
    bus.md_valid  = 1'b1;
    bus.md_rd     = 5'd11;
    bus.md_data   = 32'hBAD;
    bus.chk_addr  = 5'd0;
    for (int j = 0; j < 4; j++) begin
      tick();
      bus.md_valid = 1'b0;
      checks++;
      if (bus.write !== 1'b1 || bus.Rd_addr !== AW'(7 + j)
          || bus.Rd_data !== DW'(32'h700 + j)) begin
        errors++;
        $display("FAIL drain_%0d got %b/%0d/%h exp 1/%0d/%h", j,
                 bus.write, bus.Rd_addr, bus.Rd_data, 7 + j, 32'h700 + j);
      end
    end
    tick();
    checks++;
    if (bus.write !== 1'b0) begin
      errors++;
      $display("FAIL full_nopush got %b/%0d exp 0", bus.write, bus.Rd_addr);
    end
  endtask

  task automatic test_starve();
    int            k;
    int            stall_at;
    int            stall_cyc;
    bit            stall_now;
    logic [AW-1:0] got[$];
    logic [AW-1:0] exp[$];
    do_reset();
    k = 0;
    stall_at = -1;
    stall_cyc = 0;
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd12;
    bus.md_data  = 32'hC0DE;
    for (int i = 0; i < 12; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = AW'(k + 1);
      bus.alu_data  = DW'(32'hA000 + k);
      stall_now = bus.alu_stall;
      tick();
      bus.md_valid = 1'b0;
      if (!stall_now) k++;
      if (bus.write) got.push_back(bus.Rd_addr);
      if (bus.alu_stall) stall_cyc++;
      if (bus.alu_stall && stall_at < 0) stall_at = k;
      if (stall_now) begin
        checks++;
        if (bus.write !== 1'b1 || bus.Rd_addr !== 5'd12 || bus.Rd_data !== 32'hC0DE) begin
          errors++;
          $display("FAIL starve_md got %b/%0d/%h exp 1/12/C0DE",
                   bus.write, bus.Rd_addr, bus.Rd_data);
        end
      end
    end
    checks++;
    if (stall_at != 8 || stall_cyc != 1) begin
      errors++;
      $display("FAIL stall_point got wins=%0d cycles=%0d exp 8/1", stall_at, stall_cyc);
    end
    for (int r = 1; r <= 8; r++) exp.push_back(AW'(r));
    exp.push_back(5'd12);
    for (int r = 9; r <= k; r++) exp.push_back(AW'(r));
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL starve_order got n=%0d %p exp n=%0d %p",
               got.size(), got, exp.size(), exp);
    end
  endtask

  task automatic test_rd0();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 32'h44;
    tick();
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hFFFF;
    tick();
    checks++;
    if (bus.write !== 1'b0 || bus.Rd_addr !== 5'd4 || bus.Rd_data !== 32'h44) begin
      errors++;
      $display("FAIL alu_rd0 got %b/%0d/%h exp 0/4/44",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    idle();
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd0;
    bus.md_data  = 32'h55;
    tick();
    checks++;
    if (bus.write !== 1'b0 || bus.Rd_addr !== 5'd4 || bus.Rd_data !== 32'h44) begin
      errors++;
      $display("FAIL byp_rd0 got %b/%0d/%h exp 0/4/44",
               bus.write, bus.Rd_addr, bus.Rd_data);
    end
    idle();
  endtask

  task automatic test_random();
    bit stall_now;
    bit hold;
    int thr;
    do_reset();
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      thr = (i < 300) ? 9 : 6;
      if (!hold) begin
        bus.alu_valid = ($urandom_range(0, 9) < thr);
        bus.alu_rd    = AW'($urandom_range(0, 7));
        bus.alu_data  = DW'($urandom());
      end
      bus.md_valid = 1'($urandom_range(0, 1));
      bus.md_rd    = AW'($urandom_range(0, 7));
      bus.md_data  = DW'($urandom());
      bus.chk_addr = AW'($urandom_range(0, 7));
      #1;
      checks++;
      if (bus.md_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready c%0d got %b exp %b", i, bus.md_ready, q.size() < DEPTH);
      end
      checks++;
      if (bus.chk_hit !== model_hit(bus.chk_addr)) begin
        errors++;
        $display("FAIL rnd_hit c%0d got %b exp %b", i, bus.chk_hit, model_hit(bus.chk_addr));
      end
      checks++;
      if (bus.alu_stall !== m_drain) begin
        errors++;
        $display("FAIL rnd_stall c%0d got %b exp %b", i, bus.alu_stall, m_drain);
      end
      stall_now = bus.alu_stall;
      tick();
      hold = stall_now && bus.alu_valid;
      checks++;
      if (bus.write !== e_write || bus.Rd_addr !== e_addr || bus.Rd_data !== e_data) begin
        errors++;
        $display("FAIL rnd_wr c%0d got %b/%0d/%h exp %b/%0d/%h", i,
                 bus.write, bus.Rd_addr, bus.Rd_data, e_write, e_addr, e_data);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_alu_md();
    test_full_chk();
    test_starve();
    test_rd0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
